mpu_load_stream: RTL and testbench
==================================

# mpu_load_stream

Parametrised successor loader between external memory and the matrix register file. Accepts a load command (dimensions, destination address, traversal order), then consumes a valid/ready stream of LANES elements per beat and serialises it into one register-file write per cycle, honouring register-file stall. It adds multi-lane beats, column-major traversal, partial final beats, backpressure, a done pulse and coded errors.

## Interface
- FP, 32: element width in bits
- M, 4: max rows; MBITS = $clog2(M)
- N, 4: max columns; NBITS = $clog2(N)
- NUM_MATS, 4: number of matrix registers; MATRIX_REG_SIZE = $clog2(NUM_MATS)
- LANES, 2: elements per input beat (≥1)

Ports:
- clk  in  1  clock; one clock, all logic on posedge
- rst  in  1  reset, synchronous, active-low
- load_en_in  in  1  command strobe, sampled only in IDLE
- mem_m_load_size_in  in  MBITS+1  rows
- mem_n_load_size_in  in  NBITS+1  columns
- mem_load_addr_in  in  MATRIX_REG_SIZE  destination matrix
- mem_col_major_in  in  1  0: column index fastest; 1: row index fastest
- mem_load_valid_in  in  1  beat valid
- mem_load_element_in  in  LANES*FP  beat; lane k at bits [k*FP +: FP]
- mem_load_ready_out  out  1  beat accepted when valid && ready
- mem_load_ack_out  out  1  one-cycle command-accepted pulse
- mem_load_done_out  out  1  one-cycle pulse after last write
- mem_load_error_out  out  1  sticky error flag
- mem_load_err_code_out  out  2  01 bad dimension, 10 bad address, 00 none
- reg_load_stall_in  in  1  register file cannot take a write this cycle
- reg_load_en_out  out  1  write request
- reg_load_addr_out  out  MATRIX_REG_SIZE  destination matrix
- reg_load_element_out  out  FP  element
- reg_i_load_loc_out / reg_j_load_loc_out  out  MBITS+1 / NBITS+1  row / column
- reg_m_load_size_out / reg_n_load_size_out  out  MBITS+1 / NBITS+1  latched sizes

## Operation
- States: IDLE, LOAD, DONE.
- IDLE, load_en_in=1: m=0, n=0, m>M or n>N → error=1, code=01, stay IDLE. Else addr≥NUM_MATS (only when NUM_MATS not power of 2) → code=10. Else latch sizes/addr/mode, clear error/code, ack=1 for one cycle, pointers (i,j)=(0,0), remaining=m*n, → LOAD.
- load_en_in outside IDLE is ignored; no error.
- LOAD: LANES-entry buffer plus lane pointer and valid count. Ready = buffer empty OR (emitting its last valid lane and !reg_load_stall_in). On accept, valid count = min(LANES, remaining); excess lanes of the final beat are discarded.
- Emit: reg_load_en_out=1 while buffer non-empty; element = buffer[lane_ptr]; i/j = current pointers. Write completes when en && !stall; then advance lane_ptr, decrement remaining, step pointers.
- Pointer step, row-major: j++, at j==n → j=0, i++. Column-major: i++, at i==m → i=0, j++.
- Write completing with remaining==1 → DONE. DONE: done=1 one cycle, ready=0, → IDLE.
- Sizes/addr outputs hold latched values from ack through DONE; 0 in IDLE.

## Timing
- Reset (rst=0 at posedge): state IDLE, buffer emptied; all outputs 0, including error/code. Reset mid-load aborts with no done pulse. Stream words in flight are lost.
- Ack in the cycle after load_en_in sampled; ready may assert the cycle after ack.
- Accepted beat's lane 0 appears on reg_* the next cycle. Sustained throughput is one element per non-stalled cycle. With LANES=1 and no stall, ready stays high continuously.
- Stall freezes element, i/j and lane_ptr; en stays 1.
- Done is one cycle after the final completed write. Earliest next command is sampled the cycle after done.
- Error asserts the cycle after the bad command. It clears only on the next accepted command or reset.

## Test plan
- LANES=2, 2x3 row-major, elements 1..6 in 3 beats, no stall → writes (0,0)=1,(0,1)=2,(0,2)=3,(1,0)=4,(1,1)=5,(1,2)=6 on consecutive cycles, done one cycle after last.
- Same stream, col-major → (0,0)=1,(1,0)=2,(0,1)=3,(1,1)=4,(0,2)=5,(1,2)=6.
- 3x1, LANES=2: second beat lane 1 = 0xDEAD → exactly 3 writes, 0xDEAD never written.
- Stall high 3 cycles during element 2 of a 2x2 → element/i/j held, ready=0, total writes 4, no duplicate.
- Commands with m=0, then n=N+1 → error=1, code=01, no ack; next valid command → ack, error clears.
- rst=0 mid-load after 2 of 4 writes → all outputs 0 next cycle, no done; new 1x1 load completes normally.

Source files
------------

// File: rtl/mpu_load_stream_if.sv
// Memory-side beat stream feeding the matrix loader: valid/ready handshake,
// LANES elements per beat with lane k at bits [k*FP +: FP].
interface mpu_load_stream_if #(
  parameter int unsigned FP    = 32,
  parameter int unsigned LANES = 2
) ();
  logic                mem_load_valid_in;
  logic [LANES*FP-1:0] mem_load_element_in;
  logic                mem_load_ready_out;

  modport master (
    output mem_load_valid_in,
    output mem_load_element_in,
    input  mem_load_ready_out
  );

  modport slave (
    input  mem_load_valid_in,
    input  mem_load_element_in,
    output mem_load_ready_out
  );
endinterface

// File: rtl/mpu_load_stream.sv
// Matrix load streamer: takes a load command, then serialises LANES-wide memory
// beats into one register-file write per cycle in row- or column-major order.
module mpu_load_stream #(
  parameter int unsigned FP       = 32,
  parameter int unsigned M        = 4,
  parameter int unsigned N        = 4,
  parameter int unsigned NUM_MATS = 4,
  parameter int unsigned LANES    = 2,
  localparam int unsigned MBITS           = $clog2(M),
  localparam int unsigned NBITS           = $clog2(N),
  localparam int unsigned MATRIX_REG_SIZE = $clog2(NUM_MATS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en_in,
  input  logic [MBITS:0]             mem_m_load_size_in,
  input  logic [NBITS:0]             mem_n_load_size_in,
  input  logic [MATRIX_REG_SIZE-1:0] mem_load_addr_in,
  input  logic                       mem_col_major_in,
  mpu_load_stream_if.slave           mem_if,
  output logic                       mem_load_ack_out,
  output logic                       mem_load_done_out,
  output logic                       mem_load_error_out,
  output logic [1:0]                 mem_load_err_code_out,
  input  logic                       reg_load_stall_in,
  output logic                       reg_load_en_out,
  output logic [MATRIX_REG_SIZE-1:0] reg_load_addr_out,
  output logic [FP-1:0]              reg_load_element_out,
  output logic [MBITS:0]             reg_i_load_loc_out,
  output logic [NBITS:0]             reg_j_load_loc_out,
  output logic [MBITS:0]             reg_m_load_size_out,
  output logic [NBITS:0]             reg_n_load_size_out
);
  localparam int unsigned IW    = MBITS + 1;
  localparam int unsigned JW    = NBITS + 1;
  localparam int unsigned AW    = MATRIX_REG_SIZE;
  localparam int unsigned RBITS = $clog2(M * N + 1);
  localparam int unsigned CBITS = $clog2(LANES + 1);
  localparam int unsigned LBITS = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    m_q, m_d, i_q, i_d;
  logic [JW-1:0]    n_q, n_d, j_q, j_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             col_q, col_d;
  logic [RBITS-1:0] rem_q, rem_d, fetch_q, fetch_d;
  logic [FP-1:0]    buf_q [LANES];
  logic [FP-1:0]    buf_d [LANES];
  logic [LBITS-1:0] lane_q, lane_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [FP-1:0]    elem_q, elem_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;

  logic ready_c, wr_done_c, last_lane_c, bad_dim_c, bad_addr_c;

  assign bad_dim_c  = (mem_m_load_size_in == '0) || (mem_n_load_size_in == '0) ||
                      (mem_m_load_size_in > IW'(M)) || (mem_n_load_size_in > JW'(N));
  assign bad_addr_c = {1'b0, mem_load_addr_in} >= (AW+1)'(NUM_MATS);

  // fetch_q counts elements still to be pulled from the stream, rem_q those still to be written
  assign wr_done_c   = en_q && !reg_load_stall_in;
  assign last_lane_c = (CBITS'(lane_q) + CBITS'(1)) == cnt_q;
  assign ready_c     = (state_q == S_LOAD) && !ack_q && (fetch_q != '0) &&
                       (!en_q || (last_lane_c && !reg_load_stall_in));

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    addr_d  = addr_q;
    col_d   = col_q;
    rem_d   = rem_q;
    fetch_d = fetch_q;
    buf_d   = buf_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    elem_d  = elem_q;
    err_d   = err_q;
    code_d  = code_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_en_in) begin
          if (bad_dim_c) begin
            err_d  = 1'b1;
            code_d = 2'b01;
          end else if (bad_addr_c) begin
            err_d  = 1'b1;
            code_d = 2'b10;
          end else begin
            m_d     = mem_m_load_size_in;
            n_d     = mem_n_load_size_in;
            addr_d  = mem_load_addr_in;
            col_d   = mem_col_major_in;
            i_d     = '0;
            j_d     = '0;
            rem_d   = RBITS'(mem_m_load_size_in) * RBITS'(mem_n_load_size_in);
            fetch_d = RBITS'(mem_m_load_size_in) * RBITS'(mem_n_load_size_in);
            en_d    = 1'b0;
            lane_d  = '0;
            err_d   = 1'b0;
            code_d  = 2'b00;
            ack_d   = 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (wr_done_c) begin
          if (!col_q) begin
            if (j_q + JW'(1) == n_q) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + JW'(1);
            end
          end else begin
            if (i_q + IW'(1) == m_q) begin
              i_d = '0;
              j_d = j_q + JW'(1);
            end else begin
              i_d = i_q + IW'(1);
            end
          end
          rem_d = rem_q - RBITS'(1);
          if (last_lane_c) begin
            en_d = 1'b0;
          end else begin
            lane_d = lane_q + LBITS'(1);
            elem_d = buf_q[lane_q + LBITS'(1)];
          end
          if (rem_q == RBITS'(1)) begin
            en_d    = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
        // Refill may coincide with the final lane's write; lanes beyond the matrix are dropped
        if (ready_c && mem_if.mem_load_valid_in) begin
          for (int k = 0; k < LANES; k++) begin
            buf_d[k] = mem_if.mem_load_element_in[k*FP +: FP];
          end
          cnt_d   = (fetch_q >= RBITS'(LANES)) ? CBITS'(LANES) : CBITS'(fetch_q);
          fetch_d = fetch_q - RBITS'(cnt_d);
          lane_d  = '0;
          en_d    = 1'b1;
          elem_d  = mem_if.mem_load_element_in[FP-1:0];
        end
      end
      S_DONE: begin
        m_d     = '0;
        n_d     = '0;
        i_d     = '0;
        j_d     = '0;
        addr_d  = '0;
        col_d   = 1'b0;
        elem_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      addr_q  <= '0;
      col_q   <= 1'b0;
      rem_q   <= '0;
      fetch_q <= '0;
      for (int k = 0; k < LANES; k++) buf_q[k] <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      elem_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      rem_q   <= rem_d;
      fetch_q <= fetch_d;
      buf_q   <= buf_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      elem_q  <= elem_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign mem_if.mem_load_ready_out = ready_c;
  assign mem_load_ack_out          = ack_q;
  assign mem_load_done_out         = done_q;
  assign mem_load_error_out        = err_q;
  assign mem_load_err_code_out     = code_q;
  assign reg_load_en_out           = en_q;
  assign reg_load_addr_out         = addr_q;
  assign reg_load_element_out      = elem_q;
  assign reg_i_load_loc_out        = i_q;
  assign reg_j_load_loc_out        = j_q;
  assign reg_m_load_size_out       = m_q;
  assign reg_n_load_size_out       = n_q;
endmodule

// File: tb/tb_mpu_load_stream.sv
// Self-checking bench for mpu_load_stream: a write-order model built from matrix
// dimensions and traversal order is compared against every register-file write.
module tb_mpu_load_stream;
  localparam int unsigned FP       = 32;
  localparam int unsigned M        = 4;
  localparam int unsigned N        = 4;
  localparam int unsigned NUM_MATS = 4;
  localparam int unsigned LANES    = 2;
  localparam int unsigned MBITS    = $clog2(M);
  localparam int unsigned NBITS    = $clog2(N);
  localparam int unsigned AW       = $clog2(NUM_MATS);

  logic           clk = 1'b0;
  logic           rst;
  logic           load_en;
  logic [MBITS:0] m_in;
  logic [NBITS:0] n_in;
  logic [AW-1:0]  addr_in;
  logic           col_in;
  logic           stall;
  logic           ack, done, err, wr_en;
  logic [1:0]     code;
  logic [AW-1:0]  wr_addr;
  logic [FP-1:0]  wr_elem;
  logic [MBITS:0] wr_i, wr_m;
  logic [NBITS:0] wr_j, wr_n;

  mpu_load_stream_if #(.FP(FP), .LANES(LANES)) mem_if ();

  mpu_load_stream #(.FP(FP), .M(M), .N(N), .NUM_MATS(NUM_MATS), .LANES(LANES)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .load_en_in            (load_en),
    .mem_m_load_size_in    (m_in),
    .mem_n_load_size_in    (n_in),
    .mem_load_addr_in      (addr_in),
    .mem_col_major_in      (col_in),
    .mem_if                (mem_if),
    .mem_load_ack_out      (ack),
    .mem_load_done_out     (done),
    .mem_load_error_out    (err),
    .mem_load_err_code_out (code),
    .reg_load_stall_in     (stall),
    .reg_load_en_out       (wr_en),
    .reg_load_addr_out     (wr_addr),
    .reg_load_element_out  (wr_elem),
    .reg_i_load_loc_out    (wr_i),
    .reg_j_load_loc_out    (wr_j),
    .reg_m_load_size_out   (wr_m),
    .reg_n_load_size_out   (wr_n)
  );

  always #5 clk = ~clk;

  typedef struct { int i; int j; int e; int cyc; } wr_t;

  wr_t                 exp_q[$];
  wr_t                 log_q[$];
  logic [LANES*FP-1:0] beats_q[$];

  int   errors = 0, checks = 0, cyc = 0;
  int   exp_m = 0, exp_n = 0, exp_addr = 0;
  bit   exp_ack = 0, exp_done = 0, exp_err = 0;
  logic [1:0] exp_code = 2'b00;
  bit   chk_reset = 0, chk_idle = 0, hs = 0;
  int   stall_trig = -1, stall_cnt = 0, done_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, run at the falling edge
  task automatic monitor();
    wr_t w;
    chk("ack", 32'(ack), 32'(exp_ack));
    exp_ack = 0;
    chk("done", 32'(done), 32'(exp_done));
    if (done) done_cyc = cyc;
    exp_done = 0;
    chk("error", 32'(err), 32'(exp_err));
    chk("err_code", 32'(code), 32'(exp_code));
    if (chk_reset || chk_idle) begin
      chk("idle_en", 32'(wr_en), 0);
      chk("idle_ready", 32'(mem_if.mem_load_ready_out), 0);
      chk("idle_addr", 32'(wr_addr), 0);
      chk("idle_m", 32'(wr_m), 0);
      chk("idle_n", 32'(wr_n), 0);
    end
    if (chk_reset) begin
      chk("reset_elem", wr_elem, 0);
      chk("reset_i", 32'(wr_i), 0);
      chk("reset_j", 32'(wr_j), 0);
    end
    chk_reset = 0;
    chk_idle  = 0;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write_en", 32'(wr_en), 0);
      end else begin
        w = exp_q[0];
        chk("element", wr_elem, w.e);
        chk("i_loc", 32'(wr_i), w.i);
        chk("j_loc", 32'(wr_j), w.j);
        chk("wr_addr", 32'(wr_addr), exp_addr);
        chk("m_size", 32'(wr_m), exp_m);
        chk("n_size", 32'(wr_n), exp_n);
        if (stall) begin
          chk("ready_in_stall", 32'(mem_if.mem_load_ready_out), 0);
        end else begin
          if (stall_trig >= 0 && int'(wr_elem) == stall_trig) begin
            stall_cnt  = 3;
            stall_trig = -1;
          end
          w = exp_q.pop_front();
          w.cyc = cyc;
          log_q.push_back(w);
          if (exp_q.size() == 0) exp_done = 1;
        end
      end
    end
    hs = mem_if.mem_load_valid_in && mem_if.mem_load_ready_out;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (hs) void'(beats_q.pop_front());
    mem_if.mem_load_valid_in   = (beats_q.size() != 0);
    mem_if.mem_load_element_in = (beats_q.size() != 0) ? beats_q[0] : '0;
    if (stall_cnt > 0) begin
      stall = 1'b1;
      stall_cnt--;
    end else begin
      stall = 1'b0;
    end
  endtask

  // Expected write order from dimensions and traversal; beats padded with pad
  task automatic prep(input int m, input int n, input bit col, input int elems[8], input int pad);
    wr_t w;
    logic [LANES*FP-1:0] b;
    exp_q.delete();
    log_q.delete();
    beats_q.delete();
    done_cyc = -1;
    for (int k = 0; k < m * n; k++) begin
      w.i   = col ? (k % m) : (k / n);
      w.j   = col ? (k / m) : (k % n);
      w.e   = elems[k];
      w.cyc = 0;
      exp_q.push_back(w);
    end
    for (int s = 0; s < m * n; s += LANES) begin
      b = '0;
      for (int l = 0; l < LANES; l++) begin
        b[l*FP +: FP] = (s + l < m * n) ? FP'(elems[s+l]) : FP'(pad);
      end
      beats_q.push_back(b);
    end
    mem_if.mem_load_valid_in   = 1'b1;
    mem_if.mem_load_element_in = beats_q[0];
  endtask

  task automatic cmd(input int m, input int n, input int a, input bit col, input bit good);
    load_en = 1'b1;
    m_in    = (MBITS+1)'(m);
    n_in    = (NBITS+1)'(n);
    addr_in = AW'(a);
    col_in  = col;
    tick();
    load_en = 1'b0;
    exp_ack = good;
    if (good) begin
      exp_err  = 0;
      exp_code = 2'b00;
      exp_m    = m;
      exp_n    = n;
      exp_addr = a;
    end else begin
      exp_err  = 1;
      exp_code = 2'b01;
    end
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done_cyc < 0 && c < budget) begin
      tick();
      c++;
    end
    chk("done_within_budget", 32'(done_cyc >= 0), 1);
  endtask

  task automatic chk_log(input string name, input int idx, input int i, input int j, input int e);
    if (idx < log_q.size()) begin
      chk({name, "_i"}, log_q[idx].i, i);
      chk({name, "_j"}, log_q[idx].j, j);
      chk({name, "_e"}, log_q[idx].e, e);
    end else begin
      chk({name, "_present"}, log_q.size(), idx + 1);
    end
  endtask

  initial begin
    rst     = 1'b0;
    load_en = 1'b0;
    m_in    = '0;
    n_in    = '0;
    addr_in = '0;
    col_in  = 1'b0;
    stall   = 1'b0;
    mem_if.mem_load_valid_in   = 1'b0;
    mem_if.mem_load_element_in = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk_reset = 1;
    tick();
    rst = 1'b1;
    tick();

    // 2x3 row-major, three full beats, no stall
    prep(2, 3, 0, '{1, 2, 3, 4, 5, 6, 0, 0}, 0);
    cmd(2, 3, 1, 0, 1);
    wait_done(40);
    chk("rm_writes", log_q.size(), 6);
    chk_log("rm_w2", 2, 0, 2, 3);
    chk_log("rm_w3", 3, 1, 0, 4);
    if (log_q.size() == 6) begin
      chk("rm_back_to_back", log_q[5].cyc - log_q[0].cyc, 5);
      chk("rm_done_latency", done_cyc - log_q[5].cyc, 1);
    end
    chk_idle = 1;
    tick();

    // Same stream, column-major
    prep(2, 3, 1, '{1, 2, 3, 4, 5, 6, 0, 0}, 0);
    cmd(2, 3, 2, 1, 1);
    wait_done(40);
    chk("cm_writes", log_q.size(), 6);
    chk_log("cm_w1", 1, 1, 0, 2);
    chk_log("cm_w4", 4, 0, 2, 5);
    tick();

    // 3x1: last beat's second lane must be dropped
    prep(3, 1, 0, '{1, 2, 3, 0, 0, 0, 0, 0}, 32'hDEAD);
    cmd(3, 1, 3, 0, 1);
    wait_done(40);
    chk("partial_writes", log_q.size(), 3);
    for (int k = 0; k < log_q.size(); k++) chk("pad_never_written", 32'(log_q[k].e == 32'hDEAD), 0);
    chk_log("partial_w2", 2, 2, 0, 3);
    tick();

    // 2x2 with a 3-cycle stall on the second element
    prep(2, 2, 0, '{21, 22, 23, 24, 0, 0, 0, 0}, 0);
    stall_trig = 21;
    cmd(2, 2, 0, 0, 1);
    wait_done(40);
    chk("stall_writes", log_q.size(), 4);
    chk_log("stall_w1", 1, 0, 1, 22);
    if (log_q.size() == 4) begin
      chk("stall_hold_cycles", log_q[1].cyc - log_q[0].cyc, 4);
      chk("stall_resume", log_q[2].cyc - log_q[1].cyc, 1);
    end
    tick();

    // Bad dimensions, then a good command clears the error
    cmd(0, 2, 0, 0, 0);
    tick();
    chk("err_after_m0", 32'(err), 1);
    cmd(2, N + 1, 0, 0, 0);
    tick();
    chk("code_after_nbig", 32'(code), 32'(2'b01));
    prep(1, 2, 0, '{31, 32, 0, 0, 0, 0, 0, 0}, 0);
    cmd(1, 2, 1, 0, 1);
    wait_done(40);
    chk("recover_writes", log_q.size(), 2);
    tick();

    // Reset after two of four writes aborts without done
    prep(2, 2, 1, '{41, 42, 43, 44, 0, 0, 0, 0}, 0);
    void'(beats_q.pop_back());
    cmd(2, 2, 0, 1, 1);
    for (int c = 0; c < 40 && log_q.size() < 2; c++) tick();
    chk("abort_writes_before_reset", log_q.size(), 2);
    rst = 1'b0;
    beats_q.delete();
    exp_q.delete();
    mem_if.mem_load_valid_in = 1'b0;
    exp_done = 0;
    tick();
    rst      = 1'b1;
    exp_err  = 0;
    exp_code = 2'b00;
    chk_reset = 1;
    tick();
    repeat (3) tick();
    prep(1, 1, 0, '{77, 0, 0, 0, 0, 0, 0, 0}, 32'h99);
    cmd(1, 1, 3, 0, 1);
    wait_done(40);
    chk("post_reset_writes", log_q.size(), 1);
    chk_log("post_reset_w0", 0, 0, 0, 77);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
